// File: rtl/cpu_multicycle_pkg.sv
// Shared opcode/state types and decode helpers for the multi-cycle accumulator core.
package cpu_multicycle_pkg;

    localparam int unsigned OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_AND = 4'h7,
        OP_OR  = 4'h8,
        OP_XOR = 4'h9,
        OP_JZ  = 4'hA,
        OP_JC  = 4'hB,
        OP_HLT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_LOAD_IR  = 3'd1,
        ST_EXEC     = 3'd2,
        ST_MEM_WAIT = 3'd3,
        ST_HALTED   = 3'd4
    } state_e;

    function automatic logic is_mem_op(logic [OPC_W-1:0] op);
        return op inside {OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
    endfunction

    function automatic logic is_illegal(logic [OPC_W-1:0] op);
        return op inside {4'hC, 4'hD, 4'hE};
    endfunction

endpackage

// File: rtl/cpu_multicycle_if.sv
// Instruction and data memory bus of the accumulator core.
interface cpu_multicycle_if
    import cpu_multicycle_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic                      imem_en;
    logic [ADDR_W-1:0]         imem_addr;
    logic [ADDR_W+OPC_W-1:0]   imem_rdata;
    logic                      dmem_req;
    logic                      dmem_we;
    logic [ADDR_W-1:0]         dmem_addr;
    logic [DATA_W-1:0]         dmem_wdata;
    logic [DATA_W-1:0]         dmem_rdata;
    logic                      dmem_ack;

    modport master (
        output imem_en, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_rdata, dmem_rdata, dmem_ack
    );

    modport slave (
        input  imem_en, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_rdata, dmem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU; carry is computed one bit wider than the data path.
module cpu_alu
    import cpu_multicycle_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic [OPC_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              c_in,
    output logic [DATA_W-1:0] result,
    output logic              z,
    output logic              c,
    output logic              c_valid
);
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic            w_carry;

    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result  = a;
        w_carry = 1'b0;
        c_valid = 1'b0;
        case (op)
            OP_LDA, OP_LDI: result = b;
            OP_ADD: begin
                result  = w_sum[DATA_W-1:0];
                w_carry = w_sum[DATA_W];
                c_valid = 1'b1;
            end
            // Top bit of the widened difference is the borrow (a < b).
            OP_SUB: begin
                result  = w_diff[DATA_W-1:0];
                w_carry = w_diff[DATA_W];
                c_valid = 1'b1;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

    assign z = (result == '0);
    assign c = c_valid ? w_carry : c_in;

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle accumulator CPU: fetch/decode/execute FSM with handshaked data memory.
module cpu_multicycle
    import cpu_multicycle_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    cpu_multicycle_if.master  bus,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] acc,
    output logic              flag_z,
    output logic              flag_c,
    output logic              halt,
    output logic              illegal_op
);
    localparam int unsigned IR_W = ADDR_W + OPC_W;

    state_e            r_state;
    logic [IR_W-1:0]   r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_acc;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_halt;
    logic              r_illegal;
    logic              r_dmem_req;
    logic              r_dmem_we;

    logic [OPC_W-1:0]  w_op;
    logic [ADDR_W-1:0] w_operand;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [DATA_W-1:0] w_alu_b;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_z;
    logic              w_alu_c;
    logic              w_alu_c_valid;

    assign w_op      = r_ir[IR_W-1 -: OPC_W];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_pc_inc  = r_pc + ADDR_W'(1);
    assign w_alu_b   = (w_op == OP_LDI) ? DATA_W'(w_operand) : bus.dmem_rdata;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op      (w_op),
        .a       (r_acc),
        .b       (w_alu_b),
        .c_in    (r_flag_c),
        .result  (w_alu_res),
        .z       (w_alu_z),
        .c       (w_alu_c),
        .c_valid (w_alu_c_valid)
    );

    // Main FSM; illegal_op is decoded from the fetched word so it is high exactly in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_FETCH;
            r_ir       <= '0;
            r_pc       <= '0;
            r_acc      <= '0;
            r_flag_z   <= 1'b0;
            r_flag_c   <= 1'b0;
            r_halt     <= 1'b0;
            r_illegal  <= 1'b0;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                ST_FETCH: r_state <= ST_LOAD_IR;
                ST_LOAD_IR: begin
                    r_ir      <= bus.imem_rdata;
                    r_illegal <= is_illegal(bus.imem_rdata[IR_W-1 -: OPC_W]);
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_state <= ST_FETCH;
                    r_pc    <= w_pc_inc;
                    if (is_mem_op(w_op)) begin
                        r_pc       <= r_pc;
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= (w_op == OP_STA);
                        r_state    <= ST_MEM_WAIT;
                    end else begin
                        case (w_op)
                            OP_LDI: begin
                                r_acc    <= w_alu_res;
                                r_flag_z <= w_alu_z;
                            end
                            OP_JMP: r_pc <= w_operand;
                            OP_JZ:  if (r_flag_z) r_pc <= w_operand;
                            OP_JC:  if (r_flag_c) r_pc <= w_operand;
                            OP_HLT: begin
                                r_pc    <= r_pc;
                                r_halt  <= 1'b1;
                                r_state <= ST_HALTED;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MEM_WAIT: begin
                    if (bus.dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        r_pc       <= w_pc_inc;
                        r_state    <= ST_FETCH;
                        if (w_op != OP_STA) begin
                            r_acc    <= w_alu_res;
                            r_flag_z <= w_alu_z;
                            if (w_alu_c_valid) r_flag_c <= w_alu_c;
                        end
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Fetch strobe is a state decode, gated so it drops as soon as reset asserts.
    assign bus.imem_en    = rst_n && (r_state == ST_FETCH);
    assign bus.imem_addr  = r_pc;
    assign bus.dmem_req   = r_dmem_req;
    assign bus.dmem_we    = r_dmem_we;
    assign bus.dmem_addr  = w_operand;
    assign bus.dmem_wdata = r_acc;

    assign pc         = r_pc;
    assign acc        = r_acc;
    assign flag_z     = r_flag_z;
    assign flag_c     = r_flag_c;
    assign halt       = r_halt;
    assign illegal_op = r_illegal;

endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
Parametrised successor of the single-cycle 8-bit accumulator core. Multi-cycle FSM-based accumulator CPU with:
- external synchronous instruction memory and handshaked data memory;
- configurable data and address widths;
- zero/carry flags, logical ops, conditional branches and illegal-opcode reporting.

It is the top-level compute block of the 8-bit microcontroller; memories sit outside it.

Parameters:
DATA_W, 8, accumulator/data-memory word width (>=4, >= ADDR_W)
ADDR_W, 4, operand/PC/data-address width; instruction width = 4 + ADDR_W

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
imem_en  out  1  instruction read strobe
imem_addr  out  ADDR_W  instruction address (= pc)
imem_rdata  in  4+ADDR_W  instruction word, valid exactly one cycle after imem_en
dmem_req  out  1  data access request
dmem_we  out  1  1=write (STA), 0=read
dmem_addr  out  ADDR_W  data address (instruction operand)
dmem_wdata  out  DATA_W  write data (acc)
dmem_rdata  in  DATA_W  read data, valid in cycle dmem_ack=1
dmem_ack  in  1  access complete
pc  out  ADDR_W  program counter
acc  out  DATA_W  accumulator
flag_z  out  1  zero flag
flag_c  out  1  carry/borrow flag
halt  out  1  core halted
illegal_op  out  1  one-cycle pulse on undefined opcode

Behaviour:
- Reset (async assert, sync release): pc=0, acc=0, flag_z=0, flag_c=0, halt=0, illegal_op=0, ir=0, dmem_req=0, imem_en=0, state=FETCH. Reset mid-access drops the request; no retry.
- Instruction: ir[ADDR_W+3:ADDR_W]=opcode, ir[ADDR_W-1:0]=operand.
- FSM states: FETCH, LOAD_IR, EXEC, MEM_WAIT, HALTED.
  - FETCH: imem_en=1, imem_addr=pc; next LOAD_IR.
  - LOAD_IR: ir<=imem_rdata; next EXEC.
  - EXEC: executes non-memory ops and returns to FETCH. LDA/ADD/SUB/AND/OR/XOR/STA assert dmem_req and go to MEM_WAIT. HLT goes to HALTED.
  - MEM_WAIT: dmem_req/we/addr/wdata held stable until dmem_ack=1. On ack, complete the op, pc+1, go to FETCH.
- Latency: non-memory instruction 3 cycles; memory instruction 3 + N wait cycles. Ack in the first MEM_WAIT cycle gives 4 cycles.
- dmem_ack while dmem_req=0 is ignored.
- Opcodes:
  - 0 NOP
  - 1 LDA: acc=mem
  - 2 STA: mem=acc
  - 3 ADD: {c,acc}=acc+mem
  - 4 SUB: acc=acc-mem, c=borrow (acc<mem)
  - 5 LDI: acc=zero-extended operand
  - 6 JMP: pc=operand
  - 7 AND
  - 8 OR
  - 9 XOR
  - A JZ: pc=operand if flag_z else pc+1
  - B JC: pc=operand if flag_c else pc+1
  - F HLT
  - C/D/E: illegal. Behave as NOP (pc+1) and pulse illegal_op for the EXEC cycle.
- Flags:
  - Z is updated by LDA, LDI, ADD, SUB, AND, OR, XOR, set to (new acc==0).
  - C is updated only by ADD/SUB; unchanged by all other ops.
  - Flag updates coincide with the acc update.
- PC arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 followed by a non-jump wraps to 0.
- HALTED: halt=1. pc holds the HLT address; acc and flags are frozen; no imem_en or dmem_req. Exit only via reset.
- The ALU result width is DATA_W+1 internally; acc takes the low DATA_W bits.

Decomposition:
- Package cpu_multicycle_pkg:
  - opcode enum (4-bit) with all values above;
  - FSM state enum;
  - helper function is_mem_op(opcode).
- Sub-module cpu_alu (combinational):
  - inputs op, a, b, c_in;
  - outputs result[DATA_W-1:0], z, c, c_valid.
- The FSM, registers and memory interface stay in cpu_multicycle.

Test Plan:
- Reset then program {LDI 5, HLT} with zero-wait memory → acc=5, flag_z=0, halt=1 and pc=1 at cycle 6, with no dmem_req ever asserted.
- Memory at addr3=0xF0, program {LDI 0xF; STA 2; LDA 3; ADD 2; HLT}, ack delayed 2 cycles → dmem_req held stable across wait; dmem[2]=0x0F; acc=0xFF, flag_c=0.
- acc=0x01, SUB of mem=0x02 → acc=0xFF, flag_c=1, flag_z=0. Follow with JC 9 → pc=9. Then LDI 0, JZ 4 → pc=4.
- Opcode 0xD at pc=7 → illegal_op high exactly one cycle; acc/flags unchanged; pc=8.
- Program with no jumps filling all 16 slots with NOP → pc wraps 15→0; imem_addr follows.
- rst_n asserted low while in MEM_WAIT with dmem_req=1 → dmem_req=0 immediately (async); after release, fetch restarts at pc=0 and the late ack is ignored.
